// File: rtl/instr_fetch_seq_pkg.sv
// Shared encodings for the instruction fetch sequencer: FSM states, next-PC
// select codes and the MIPS opcode/funct values that drive next-PC selection.
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StDecode,
    StIssue,
    StFault
  } state_e;

  // Next-PC select codes, shared with the PC mux.
  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_REG    = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] word);
    return word[5:0];
  endfunction

endpackage

// File: rtl/next_pc_decode.sv
// Combinational next-PC select decode from an instruction word and the
// branch compare flag.
module next_pc_decode
  import instr_fetch_seq_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [1:0]  pc_sel
);

  always_comb begin
    pc_sel = SEL_SEQ;
    case (opcode_of(instr))
      OP_J, OP_JAL: pc_sel = SEL_JUMP;
      OP_BEQ:       if (zero) pc_sel = SEL_BRANCH;
      OP_BNE:       if (!zero) pc_sel = SEL_BRANCH;
      OP_RTYPE:     if (funct_of(instr) == FN_JR) pc_sel = SEL_REG;
      default:      pc_sel = SEL_SEQ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: requests a word at the current PC, latches it,
// decodes the next-PC select and pulses pc_load; faults on misalignment or timeout.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [1:0]  RESET_PC_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [1:0]  pc_sel,
  output logic [15:0] immediate,
  output logic [25:0] jump_address,
  output logic        pc_load,
  output logic        fault
);

  // Fault fires on the edge where the counter would reach TIMEOUT-1.
  localparam logic [3:0] WaitFault = 4'(TIMEOUT - 2);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  pc_sel_q, pc_sel_d;
  logic [1:0]  dec_sel;
  logic        start_fetch;

  next_pc_decode u_next_pc_decode (
    .instr  (instr_q),
    .zero   (zero),
    .pc_sel (dec_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      pc_sel_q <= RESET_PC_SEL;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_sel_q <= pc_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pc_sel_d    = pc_sel_q;
    start_fetch = 1'b0;

    case (state_q)
      StIdle: start_fetch = 1'b1;
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = StDecode;
        end else begin
          wait_d = wait_q + 4'd1;
          if (wait_q == WaitFault) state_d = StFault;
        end
      end
      StDecode: begin
        pc_sel_d = dec_sel;
        if (!stall) state_d = StIssue;
      end
      StIssue: if (!stall) start_fetch = 1'b1;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase

    // A misaligned PC never issues a request.
    if (start_fetch) begin
      if (pc[1:0] != 2'b00) begin
        state_d = StFault;
      end else begin
        state_d = StReq;
        addr_d  = pc;
        wait_d  = '0;
      end
    end
  end

  assign imem_req     = (state_q == StReq);
  assign imem_addr    = addr_q;
  assign instr        = instr_q;
  assign instr_valid  = (state_q == StDecode) || (state_q == StIssue);
  assign pc_sel       = pc_sel_q;
  assign immediate    = instr_q[15:0];
  assign jump_address = instr_q[25:0];
  assign pc_load      = (state_q == StIssue) && !stall;
  assign fault        = (state_q == StFault);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed self-checking bench for instr_fetch_seq.
module tb_instr_fetch_seq;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        zero;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  pc_sel;
  logic [15:0] immediate;
  logic [25:0] jump_address;
  logic        pc_load;
  logic        fault;

  int nvec = 0;
  int nerr = 0;

  instr_fetch_seq #(
    .TIMEOUT      (16),
    .RESET_PC_SEL (2'd0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .zero         (zero),
    .stall        (stall),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_sel       (pc_sel),
    .immediate    (immediate),
    .jump_address (jump_address),
    .pc_load      (pc_load),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns at the falling edge, where outputs are sampled.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered in the first REQ cycle; leaves in the first REQ cycle of the next fetch.
  task automatic fetch(input int waits, input logic [31:0] data, input logic z,
                       input logic [1:0] exp_sel);
    check("req_high", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, pc);
    for (int i = 0; i < waits; i++) begin
      cyc();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_nofault", {31'd0, fault}, 32'd0);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    zero      = z;
    cyc();
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    check("dec_instr", instr, data);
    check("dec_valid", {31'd0, instr_valid}, 32'd1);
    check("dec_req_low", {31'd0, imem_req}, 32'd0);
    check("dec_no_load", {31'd0, pc_load}, 32'd0);
    cyc();
    check("iss_pc_sel", {30'd0, pc_sel}, {30'd0, exp_sel});
    check("iss_pc_load", {31'd0, pc_load}, 32'd1);
    check("iss_valid", {31'd0, instr_valid}, 32'd1);
    check("iss_imm", {16'd0, immediate}, {16'd0, data[15:0]});
    check("iss_jaddr", {6'd0, jump_address}, {6'd0, data[25:0]});
    cyc();
    check("next_no_load", {31'd0, pc_load}, 32'd0);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_valid", {31'd0, instr_valid}, 32'd0);
    check("held_pc_sel", {30'd0, pc_sel}, {30'd0, exp_sel});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc_sel"}, {30'd0, pc_sel}, 32'd0);
    check({tag, "_pc_load"}, {31'd0, pc_load}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    pc        = 32'h0040_0000;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    zero      = 1'b0;
    stall     = 1'b0;
    #1;
    check_reset_outputs("rst");

    // Normal fetches at an aligned PC.
    cyc();
    reset_n = 1'b1;
    cyc();
    check("first_addr", imem_addr, 32'h0040_0000);
    fetch(2, 32'h0810_0004, 1'b0, 2'd1);
    fetch(0, 32'h1109_FFFE, 1'b1, 2'd2);
    fetch(0, 32'h1109_FFFE, 1'b0, 2'd0);
    fetch(0, 32'h03E0_0008, 1'b0, 2'd3);
    fetch(0, 32'h1509_000A, 1'b0, 2'd2);

    // Ack on the 15th REQ cycle still beats the timeout.
    fetch(14, 32'h0000_0000, 1'b0, 2'd0);

    // No ack: still requesting on the 15th REQ cycle, faulted by the 16th.
    for (int i = 0; i < 14; i++) cyc();
    check("to_still_req", {31'd0, imem_req}, 32'd1);
    check("to_not_yet", {31'd0, fault}, 32'd0);
    cyc();
    cyc();
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_req_low", {31'd0, imem_req}, 32'd0);
    check("to_valid_low", {31'd0, instr_valid}, 32'd0);
    check("to_no_load", {31'd0, pc_load}, 32'd0);
    imem_ack  = 1'b1;
    imem_data = 32'h0810_0004;
    cyc();
    imem_ack  = 1'b0;
    check("fault_sticky", {31'd0, fault}, 32'd1);

    // Misaligned PC goes straight to FAULT without a request.
    reset_n = 1'b0;
    #1;
    check("rst2_fault", {31'd0, fault}, 32'd0);
    pc = 32'h0040_0002;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mis_req_low", {31'd0, imem_req}, 32'd0);
      check("mis_fault", {31'd0, fault}, 32'd1);
    end

    // Stall held in ISSUE; ack outside REQ and zero changes must be ignored.
    reset_n = 1'b0;
    pc      = 32'h0040_0000;
    cyc();
    reset_n = 1'b1;
    cyc();
    check("st_req", {31'd0, imem_req}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = 32'h1109_FFFE;
    zero      = 1'b1;
    cyc();
    imem_ack  = 1'b0;
    cyc();
    stall = 1'b1;
    #1;
    check("st_no_load0", {31'd0, pc_load}, 32'd0);
    zero      = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("st_no_load", {31'd0, pc_load}, 32'd0);
      check("st_valid", {31'd0, instr_valid}, 32'd1);
      check("st_pc_sel", {30'd0, pc_sel}, 32'd2);
      check("st_instr", instr, 32'h1109_FFFE);
    end
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    stall     = 1'b0;
    #1;
    check("st_load", {31'd0, pc_load}, 32'd1);
    cyc();
    check("st_after_load", {31'd0, pc_load}, 32'd0);
    check("st_after_req", {31'd0, imem_req}, 32'd1);

    // Reset in the middle of a request; a late ack must not be captured.
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    cyc();
    cyc();
    check("late_ack_instr", instr, 32'd0);
    check("late_ack_req", {31'd0, imem_req}, 32'd0);
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    reset_n   = 1'b1;
    cyc();
    check("restart_instr", instr, 32'd0);
    fetch(1, 32'h0C00_0010, 1'b0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The block SHALL have these parameters: TIMEOUT, 16, maximum wait cycles for imem_ack before fault; RESET_PC_SEL, 2'd0, pc_sel value driven out of reset.
REQ-002 The block SHALL have these ports:
clk  input  1  single clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
pc  input  32  current program counter from PC register
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, pc latched at request start
imem_ack  input  1  memory response valid; imem_data sampled same edge
imem_data  input  32  fetched instruction word
zero  input  1  rs==rt compare flag for branch resolution
stall  input  1  hold-off from downstream; freezes DECODE/ISSUE
instr  output  32  latched instruction
instr_valid  output  1  high while instr holds a decoded word
pc_sel  output  2  next-PC select: 0 seq, 1 jump, 2 branch, 3 register
immediate  output  16  instr[15:0]
jump_address  output  26  instr[25:0]
pc_load  output  1  one-cycle pulse: PC register loads next PC
fault  output  1  sticky error flag

Function
REQ-003 FSM states SHALL be IDLE, REQ, DECODE, ISSUE, FAULT.
REQ-004 IDLE SHALL move to REQ on the first clk edge after reset_n deasserts.
REQ-005 On entry to REQ, imem_addr SHALL capture pc; imem_addr SHALL not change while imem_req is high.
REQ-006 If pc[1:0] != 0 at REQ entry, the block SHALL go to FAULT without asserting imem_req.
REQ-007 In REQ, imem_req SHALL stay high until imem_ack is sampled high; on that edge instr SHALL capture imem_data and state SHALL go to DECODE.
REQ-008 A 4-bit wait counter SHALL clear at REQ entry and increment each REQ cycle without ack; reaching TIMEOUT-1 without ack SHALL go to FAULT.
REQ-009 Ack on the same edge as the counter reaching TIMEOUT-1 SHALL win; no fault.
REQ-010 In DECODE, pc_sel SHALL be: opcode 6'h02/6'h03 -> 1; opcode 6'h04 with zero=1 -> 2; opcode 6'h05 with zero=0 -> 2; opcode 6'h00 with funct 6'h08 -> 3; else 0.
REQ-011 zero SHALL be sampled in DECODE only; pc_sel SHALL be registered and held stable through ISSUE.
REQ-012 instr_valid SHALL be high in DECODE and ISSUE, low elsewhere.
REQ-013 DECODE SHALL advance to ISSUE when stall=0, else hold.
REQ-014 ISSUE SHALL assert pc_load for exactly one cycle when stall=0, then go to REQ; with stall=1 it SHALL hold with pc_load=0.
REQ-015 Latency: ack edge to pc_load high SHALL be 2 cycles with no stall.
REQ-016 immediate and jump_address SHALL be combinational slices of the registered instr.
REQ-017 FAULT SHALL be terminal until reset: fault=1, imem_req=0, pc_load=0, instr_valid=0.
REQ-018 imem_ack outside REQ SHALL be ignored.

Reset
REQ-019 While reset_n=0, asynchronously: state=IDLE, imem_req=0, imem_addr=0, instr=0, instr_valid=0, pc_sel=RESET_PC_SEL, pc_load=0, fault=0, wait counter=0.
REQ-020 Reset mid-REQ SHALL drop imem_req immediately; any later ack SHALL be ignored until the next REQ.

Structure
REQ-021 The shared package SHALL hold the state encoding, PC select codes (SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_REG) and opcode/funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, FN_JR); the PC mux SHALL use the same select codes.
REQ-022 The pc_sel decode SHALL be one combinational sub-module, next_pc_decode (inputs instr, zero; output pc_sel).

Verification
REQ-023 pc=0x00400000; ack after 2 cycles with data 0x08100004 (j) -> imem_addr=0x00400000, pc_sel=1, jump_address=0x0100004, pc_load pulses 2 cycles after ack.
REQ-024 data 0x1109FFFE (beq), zero=1 -> pc_sel=2, immediate=0xFFFE; repeat with zero=0 -> pc_sel=0.
REQ-025 data 0x03E00008 (jr $ra) -> pc_sel=3; data 0x1509000A (bne), zero=0 -> pc_sel=2.
REQ-026 No ack for 16 cycles -> fault=1, imem_req=0; ack on 15th wait cycle -> no fault, normal DECODE.
REQ-027 pc=0x00400002 -> fault=1, imem_req never asserted; stall=1 for 5 cycles in ISSUE -> pc_load only after stall drops, pc_sel unchanged.
REQ-028 reset_n low mid-REQ -> all outputs at reset values asynchronously; late ack ignored; fetch restarts after release.
